// File: rtl/spi_slave.sv
`timescale 1ns/1ps
// SPI mode-0 slave with 8-bit frames sent MSB first, plus a four-word CPU register port.
// SCLK, CS_N and MOSI are resynchronized into clk, and their edges are taken from one extra flop.
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        CS,
  input  logic [1:0]  adresse,
  input  logic        write,
  input  logic [15:0] DATAout,
  output logic [15:0] DATAin,
  input  logic        sclk_in,
  input  logic        cs_n_in,
  input  logic        mosi_in,
  output logic        miso,
  output logic        miso_oe,
  output logic        irq
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_STAT = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;

  // Input synchronizers. The top bit of sclk and cs_n is the edge-detect stage.
  logic [SYNC_STAGES:0]   sclk_sync_q;
  logic [SYNC_STAGES:0]   cs_n_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_n_sync_q <= '1;
      mosi_sync_q <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-1:0], sclk_in};
      cs_n_sync_q <= {cs_n_sync_q[SYNC_STAGES-1:0], cs_n_in};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
    end
  end

  logic sclk_rise;
  logic sclk_fall;
  logic cs_fall;
  logic cs_rise;
  logic mosi_s;

  assign sclk_rise = sclk_sync_q[SYNC_STAGES-1] & ~sclk_sync_q[SYNC_STAGES];
  assign sclk_fall = ~sclk_sync_q[SYNC_STAGES-1] & sclk_sync_q[SYNC_STAGES];
  assign cs_fall   = ~cs_n_sync_q[SYNC_STAGES-1] & cs_n_sync_q[SYNC_STAGES];
  assign cs_rise   = cs_n_sync_q[SYNC_STAGES-1] & ~cs_n_sync_q[SYNC_STAGES];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];

  // Architectural state
  state_t     state_q,    state_d;
  logic [2:0] bitcnt_q,   bitcnt_d;
  logic [6:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] tx_buf_q,   tx_buf_d;
  logic       tx_valid_q, tx_valid_d;
  logic [7:0] rxdata_q,   rxdata_d;
  logic       rxf_q,      rxf_d;
  logic       ovr_q,      ovr_d;
  logic       udr_q,      udr_d;
  logic       frm_q,      frm_d;
  logic [2:0] ctrl_q,     ctrl_d;
  logic       irq_q,      irq_d;

  logic en;
  logic bus_rd_data;
  logic bus_wr_data;
  logic bus_wr_stat;
  logic bus_wr_ctrl;
  logic [7:0] rx_byte;
  logic unused_dataout_hi;

  assign en                = ctrl_q[0];
  assign bus_rd_data       = CS & ~write & (adresse == ADDR_DATA);
  assign bus_wr_data       = CS &  write & (adresse == ADDR_DATA);
  assign bus_wr_stat       = CS &  write & (adresse == ADDR_STAT);
  assign bus_wr_ctrl       = CS &  write & (adresse == ADDR_CTRL);
  assign rx_byte           = {rx_shift_q, mosi_s};
  assign unused_dataout_hi = ^DATAout[15:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bitcnt_q   <= 3'd0;
      rx_shift_q <= 7'd0;
      tx_shift_q <= 8'hFF;
      tx_buf_q   <= 8'hFF;
      tx_valid_q <= 1'b0;
      rxdata_q   <= 8'h00;
      rxf_q      <= 1'b0;
      ovr_q      <= 1'b0;
      udr_q      <= 1'b0;
      frm_q      <= 1'b0;
      ctrl_q     <= 3'd0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      tx_buf_q   <= tx_buf_d;
      tx_valid_q <= tx_valid_d;
      rxdata_q   <= rxdata_d;
      rxf_q      <= rxf_d;
      ovr_q      <= ovr_d;
      udr_q      <= udr_d;
      frm_q      <= frm_d;
      ctrl_q     <= ctrl_d;
      irq_q      <= irq_d;
    end
  end

  logic do_load;
  logic byte_done;
  logic frm_set;
  logic udr_set;

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    tx_buf_d   = tx_buf_q;
    tx_valid_d = tx_valid_q;
    rxdata_d   = rxdata_q;
    rxf_d      = rxf_q;
    ovr_d      = ovr_q;
    udr_d      = udr_q;
    frm_d      = frm_q;
    ctrl_d     = ctrl_q;
    do_load    = 1'b0;
    byte_done  = 1'b0;
    frm_set    = 1'b0;
    udr_set    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en && cs_fall) begin
          state_d    = ST_ACTIVE;
          bitcnt_d   = 3'd0;
          rx_shift_d = 7'd0;
          do_load    = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (!en) begin
          state_d  = ST_IDLE;
          bitcnt_d = 3'd0;
        end else if (cs_rise) begin
          state_d  = ST_IDLE;
          bitcnt_d = 3'd0;
          frm_set  = (bitcnt_q != 3'd0);
        end else if (sclk_rise) begin
          rx_shift_d = rx_byte[6:0];
          bitcnt_d   = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            byte_done = 1'b1;
            do_load   = 1'b1;
          end
        end else if (sclk_fall && bitcnt_q != 3'd0) begin
          tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The load sees the buffer as it was before any write in this same cycle.
    if (do_load) begin
      if (tx_valid_q) begin
        tx_shift_d = tx_buf_q;
        tx_valid_d = 1'b0;
      end else begin
        tx_shift_d = 8'hFF;
        udr_set    = 1'b1;
      end
    end

    if (bus_wr_data) begin
      tx_buf_d   = DATAout[7:0];
      tx_valid_d = 1'b1;
    end

    if (bus_rd_data) begin
      rxf_d = 1'b0;
    end

    // A byte that lands while RXDATA is being read replaces it cleanly.
    if (byte_done) begin
      if (rxf_q && !bus_rd_data) begin
        ovr_d = 1'b1;
      end else begin
        rxdata_d = rx_byte;
        rxf_d    = 1'b1;
      end
    end

    if (bus_wr_stat) begin
      if (DATAout[2]) ovr_d = 1'b0;
      if (DATAout[3]) udr_d = 1'b0;
      if (DATAout[4]) frm_d = 1'b0;
    end
    if (udr_set) udr_d = 1'b1;
    if (frm_set) frm_d = 1'b1;

    if (bus_wr_ctrl) begin
      ctrl_d = DATAout[2:0];
    end

    irq_d = en & ((ctrl_q[1] & rxf_q) | (ctrl_q[2] & ~tx_valid_q));
  end

  always_comb begin
    DATAin = 16'h0000;
    if (CS) begin
      case (adresse)
        ADDR_DATA: DATAin = {8'h00, rxdata_q};
        ADDR_STAT: DATAin = {10'd0, (state_q == ST_ACTIVE), frm_q, udr_q, ovr_q, ~tx_valid_q, rxf_q};
        ADDR_CTRL: DATAin = {13'd0, ctrl_q};
        default:   DATAin = 16'h0000;
      endcase
    end
  end

  assign miso_oe = (state_q == ST_ACTIVE);
  assign miso    = (state_q == ST_ACTIVE) & tx_shift_q[7];
  assign irq     = irq_q;

endmodule

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps
// Self-checking bench for spi_slave. A bit-banged mode-0 master drives the slave, and a
// register-level reference model built from the block's rules supplies every expected value.
module tb_spi_slave;

  localparam int SYNC = 2;
  localparam int H    = 8;   // SCLK half period in clk cycles (SCLK = clk/16)

  logic        clk;
  logic        rst_n;
  logic        CS;
  logic [1:0]  adresse;
  logic        write;
  logic [15:0] DATAout;
  logic [15:0] DATAin;
  logic        sclk_in;
  logic        cs_n_in;
  logic        mosi_in;
  logic        miso;
  logic        miso_oe;
  logic        irq;

  spi_slave #(.SYNC_STAGES(SYNC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .CS      (CS),
    .adresse (adresse),
    .write   (write),
    .DATAout (DATAout),
    .DATAin  (DATAin),
    .sclk_in (sclk_in),
    .cs_n_in (cs_n_in),
    .mosi_in (mosi_in),
    .miso    (miso),
    .miso_oe (miso_oe),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] m_rxdata;
  logic       m_rxf, m_ovr, m_udr, m_frm;
  logic [7:0] m_txbuf;
  logic       m_txvalid;
  logic [2:0] m_ctrl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rxdata = 8'h00; m_rxf = 0; m_ovr = 0; m_udr = 0; m_frm = 0;
    m_txbuf = 8'hFF; m_txvalid = 0; m_ctrl = 3'd0;
  endtask

  function automatic logic [15:0] exp_status(input logic busy);
    return {10'd0, busy, m_frm, m_udr, m_ovr, ~m_txvalid, m_rxf};
  endfunction

  function automatic logic exp_irq();
    return m_ctrl[0] & ((m_ctrl[1] & m_rxf) | (m_ctrl[2] & ~m_txvalid));
  endfunction

  task automatic model_load(output logic [7:0] b);
    if (m_txvalid) begin
      b = m_txbuf;
      m_txvalid = 0;
    end else begin
      b = 8'hFF;
      m_udr = 1;
    end
  endtask

  task automatic model_complete(input logic [7:0] b, input bit with_read);
    if (with_read || !m_rxf) begin
      m_rxdata = b;
      m_rxf = 1;
    end else begin
      m_ovr = 1;
    end
  endtask

  // Expected master-side view of a frame: one load at start, another after every full byte.
  task automatic model_frame(input logic [31:0] dout, input int nbits, input bit end_cs,
                             input bit wr_start, input logic [7:0] wr_byte, input bit rd_last,
                             output logic [31:0] exp_din, output logic [15:0] exp_rd);
    logic [7:0] cur;
    logic [7:0] rxb;
    exp_din = 32'd0;
    exp_rd  = 16'd0;
    rxb     = 8'd0;
    model_load(cur);
    if (wr_start) begin
      m_txbuf = wr_byte;
      m_txvalid = 1;
    end
    for (int i = 0; i < nbits; i++) begin
      exp_din = {exp_din[30:0], cur[7 - (i % 8)]};
      rxb = {rxb[6:0], dout[nbits - 1 - i]};
      if (i % 8 == 7) begin
        if (rd_last && i == nbits - 1) exp_rd = {8'h00, m_rxdata};
        model_complete(rxb, rd_last && (i == nbits - 1));
        model_load(cur);
      end
    end
    if (end_cs && (nbits % 8) != 0) m_frm = 1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    CS = 1'b1; write = 1'b1; adresse = a; DATAout = d;
    @(negedge clk);
    CS = 1'b0; write = 1'b0;
    case (a)
      2'd0: begin m_txbuf = d[7:0]; m_txvalid = 1; end
      2'd1: begin
        if (d[2]) m_ovr = 0;
        if (d[3]) m_udr = 0;
        if (d[4]) m_frm = 0;
      end
      2'd2: m_ctrl = d[2:0];
      default: ;
    endcase
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
    @(negedge clk);
    CS = 1'b1; write = 1'b0; adresse = a;
    #1 d = DATAin;
    @(negedge clk);
    CS = 1'b0;
    if (a == 2'd0) m_rxf = 0;
  endtask

  // Bus access timed so its clock edge coincides with the slave acting on an SPI edge driven just before.
  task automatic coinc_bus(input logic is_wr, input logic [1:0] a, input logic [15:0] d,
                           output logic [15:0] rd);
    repeat (SYNC) @(negedge clk);
    CS = 1'b1; write = is_wr; adresse = a; DATAout = d;
    #1 rd = DATAin;
    @(negedge clk);
    CS = 1'b0; write = 1'b0;
    repeat (H - SYNC - 1) @(negedge clk);
  endtask

  task automatic spi_frame(input logic [31:0] dout, input int nbits, input bit end_cs,
                           input bit wr_start, input logic [7:0] wr_byte, input bit rd_last,
                           output logic [31:0] din, output logic [15:0] rd_val);
    din = 32'd0;
    rd_val = 16'd0;
    @(negedge clk);
    cs_n_in = 1'b0;
    if (wr_start) coinc_bus(1'b1, 2'd0, {8'h00, wr_byte}, rd_val);
    else repeat (H) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi_in = dout[nbits - 1 - i];
      repeat (H) @(negedge clk);
      din = {din[30:0], miso};
      sclk_in = 1'b1;
      if (rd_last && i == nbits - 1) coinc_bus(1'b0, 2'd0, 16'h0000, rd_val);
      else repeat (H) @(negedge clk);
      sclk_in = 1'b0;
    end
    repeat (H) @(negedge clk);
    if (end_cs) begin
      cs_n_in = 1'b1;
      repeat (H) @(negedge clk);
    end
  endtask

  task automatic do_frame(input string tag, input logic [31:0] dout, input int nbits,
                          input bit end_cs, input bit wr_start, input logic [7:0] wr_byte,
                          input bit rd_last);
    logic [31:0] din, exp_din;
    logic [15:0] rd_val, exp_rd;
    model_frame(dout, nbits, end_cs, wr_start, wr_byte, rd_last, exp_din, exp_rd);
    spi_frame(dout, nbits, end_cs, wr_start, wr_byte, rd_last, din, rd_val);
    $display("frame %s: %0d bits mosi=%h miso=%h", tag, nbits, dout, din);
    chk({tag, ".miso"}, din, exp_din);
    if (rd_last) chk({tag, ".rd"}, {16'd0, rd_val}, {16'd0, exp_rd});
  endtask

  task automatic check_regs(input string tag);
    logic [15:0] d;
    repeat (2) @(negedge clk);
    chk({tag, ".irq"}, {31'd0, irq}, {31'd0, exp_irq()});
    chk({tag, ".oe"}, {31'd0, miso_oe}, 32'd0);
    bus_read(2'd1, d);
    chk({tag, ".status"}, {16'd0, d}, {16'd0, exp_status(1'b0)});
    bus_read(2'd2, d);
    chk({tag, ".ctrl"}, {16'd0, d}, {29'd0, m_ctrl});
    bus_read(2'd3, d);
    chk({tag, ".addr3"}, {16'd0, d}, 32'd0);
  endtask

  task automatic check_rx(input string tag);
    logic [15:0] d;
    logic [15:0] e;
    e = {8'h00, m_rxdata};
    bus_read(2'd0, d);
    chk({tag, ".rxdata"}, {16'd0, d}, {16'd0, e});
  endtask

  initial begin
    logic [15:0] d;
    logic [31:0] din, r;
    logic [15:0] rdv;
    logic [7:0]  b;
    int nb;

    rst_n = 1'b0; CS = 1'b0; adresse = 2'd0; write = 1'b0; DATAout = 16'h0000;
    sclk_in = 1'b0; cs_n_in = 1'b1; mosi_in = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    chk("rst.miso", {31'd0, miso}, 32'd0);
    chk("rst.oe", {31'd0, miso_oe}, 32'd0);
    chk("rst.irq", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;

    // Reset state, bus decode and CS gating
    check_regs("reset");
    check_rx("reset");
    adresse = 2'd1; #1;
    chk("cs0.datain", {16'd0, DATAin}, 32'd0);
    bus_write(2'd3, 16'hFFFF);
    check_regs("addr3wr");

    // Basic byte exchange
    bus_write(2'd2, 16'h0007);
    check_regs("en");
    bus_write(2'd0, 16'h00A5);
    check_regs("txfull");
    do_frame("basic", 32'h3C, 8, 1, 0, 8'h00, 0);
    check_regs("basic");
    check_rx("basic");
    bus_write(2'd1, 16'h001C);
    check_regs("basic.clr");

    // Two bytes with only one TXDATA write: underrun, W1C of UDR
    bus_write(2'd0, 16'h005A);
    r = $urandom;
    do_frame("udr", r & 32'hFFFF, 16, 1, 0, 8'h00, 0);
    check_regs("udr");
    bus_write(2'd1, 16'h0008);
    check_regs("udr.w1c");
    check_rx("udr");
    bus_write(2'd1, 16'h001C);

    // Overrun
    do_frame("ovr", 32'h1122, 16, 1, 0, 8'h00, 0);
    check_regs("ovr");
    check_rx("ovr");
    bus_write(2'd1, 16'h001C);

    // Partial frame then a full one
    r = $urandom;
    do_frame("frm", r & 32'h1F, 5, 1, 0, 8'h00, 0);
    check_regs("frm");
    do_frame("after_frm", 32'h81, 8, 1, 0, 8'h00, 0);
    check_rx("after_frm");
    bus_write(2'd1, 16'h001C);

    // Byte completion coinciding with an RXDATA read
    r = $urandom;
    do_frame("pre_coinc", r & 32'hFF, 8, 1, 0, 8'h00, 0);
    r = $urandom;
    do_frame("coinc_rd", r & 32'hFF, 8, 1, 0, 8'h00, 1);
    check_regs("coinc_rd");
    check_rx("coinc_rd");
    bus_write(2'd1, 16'h001C);

    // TXDATA write coinciding with an empty-buffer load
    r = $urandom;
    b = 8'($urandom);
    do_frame("coinc_wr", r & 32'hFFFF, 16, 1, 1, b, 0);
    check_regs("coinc_wr");
    check_rx("coinc_wr");
    bus_write(2'd1, 16'h001C);

    // EN cleared mid-frame, and no frame start while disabled
    bus_write(2'd0, {8'h00, 8'($urandom)});
    r = $urandom;
    do_frame("en_clr", r & 32'hF, 4, 0, 0, 8'h00, 0);
    chk("en_clr.oe", {31'd0, miso_oe}, 32'd1);
    bus_read(2'd1, d);
    chk("en_clr.busy", {16'd0, d}, {16'd0, exp_status(1'b1)});
    bus_write(2'd2, 16'h0000);
    repeat (2) @(negedge clk);
    cs_n_in = 1'b1;
    repeat (H) @(negedge clk);
    check_regs("en_clr");
    spi_frame(32'hC3, 8, 1, 0, 8'h00, 0, din, rdv);
    chk("dis.miso", din, 32'd0);
    check_regs("dis");
    bus_write(2'd2, 16'h0007);
    r = $urandom;
    do_frame("reen", r & 32'hFF, 8, 1, 0, 8'h00, 0);
    check_rx("reen");
    bus_write(2'd1, 16'h001C);

    // Reset mid-frame
    bus_write(2'd0, 16'h0066);
    do_frame("rst_mid", 32'h5, 3, 0, 0, 8'h00, 0);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rstmid.miso", {31'd0, miso}, 32'd0);
    chk("rstmid.oe", {31'd0, miso_oe}, 32'd0);
    chk("rstmid.irq", {31'd0, irq}, 32'd0);
    CS = 1'b1; adresse = 2'd1; #1;
    chk("rstmid.status", {16'd0, DATAin}, {16'd0, exp_status(1'b0)});
    CS = 1'b0;
    cs_n_in = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_regs("rstmid");
    check_rx("rstmid");
    bus_write(2'd2, 16'h0007);
    bus_write(2'd0, 16'h00E7);
    r = $urandom;
    do_frame("post_rst", r & 32'hFF, 8, 1, 0, 8'h00, 0);
    check_regs("post_rst");
    check_rx("post_rst");
    bus_write(2'd1, 16'h001C);

    // Randomized traffic
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 1) == 1) bus_write(2'd0, {8'h00, 8'($urandom)});
      case ($urandom_range(0, 3))
        0: nb = 8;
        1: nb = 16;
        2: nb = 24;
        default: nb = $urandom_range(1, 7);
      endcase
      r = $urandom;
      if (nb < 32) r = r & ((32'd1 << nb) - 32'd1);
      do_frame($sformatf("rnd%0d", it), r, nb, 1, 0, 8'h00, 0);
      check_regs($sformatf("rnd%0d", it));
      if ($urandom_range(0, 1) == 1) check_rx($sformatf("rnd%0d", it));
      if ($urandom_range(0, 2) == 0) bus_write(2'd1, {11'd0, 3'($urandom), 2'd0});
      if ($urandom_range(0, 3) == 0) bus_write(2'd2, {13'd0, 2'($urandom), 1'b1});
    end
    check_regs("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
